// File: rtl/neopix_frame_reader.sv
// WS2812 frame reader: fetches GRB words from the frame buffer and
// serialises them onto one NeoPixel data line, then holds the latch low.
module neopix_frame_reader #(
    parameter int NUM_LEDS  = 8,
    parameter int ADDR_W    = 9,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 3000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [31:0]       q,
    output logic              busy,
    output logic              done,
    output logic              dout
);

    localparam int MAXC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam int LW   = ADDR_W + 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CYC);
    localparam logic [CW-1:0] RD_LAT   = CW'(2);
    localparam logic [CW-1:0] PF_CAP   = CW'(3);
    localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rdaddr_q;
    logic              busy_q;
    logic              done_q;
    logic              dout_q;
    logic [23:0]       shreg_q;
    logic [23:0]       nxt_q;
    logic [LW-1:0]     led_cnt_q;
    logic [4:0]        bit_idx_q;
    logic [CW-1:0]     bit_cnt_q;

    // dout is registered, so it is computed from the count it will hold next
    function automatic logic hi(input logic b, input logic [CW-1:0] c);
        hi = c < (b ? T1H : T0H);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rdaddr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= 1'b0;
            shreg_q   <= '0;
            nxt_q     <= '0;
            led_cnt_q <= '0;
            bit_idx_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        state_q   <= FETCH;
                        rdaddr_q  <= '0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                    end
                end
                FETCH: begin
                    if (bit_cnt_q == RD_LAT) begin
                        shreg_q   <= q[23:0];
                        led_cnt_q <= '0;
                        bit_idx_q <= 5'd23;
                        bit_cnt_q <= '0;
                        dout_q    <= hi(q[23], '0);
                        state_q   <= SHIFT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    // next word is requested during bit 23 and lands in nxt 3 edges later
                    if (bit_idx_q == 5'd23 && bit_cnt_q == '0 && led_cnt_q < LED_LAST)
                        rdaddr_q <= ADDR_W'(led_cnt_q + 1'b1);
                    if (bit_idx_q == 5'd23 && bit_cnt_q == PF_CAP)
                        nxt_q <= q[23:0];
                    if (bit_cnt_q != BIT_LAST) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        dout_q    <= hi(shreg_q[bit_idx_q], bit_cnt_q + 1'b1);
                    end else if (bit_idx_q != 5'd0) begin
                        bit_idx_q <= bit_idx_q - 5'd1;
                        bit_cnt_q <= '0;
                        dout_q    <= hi(shreg_q[bit_idx_q - 5'd1], '0);
                    end else if (led_cnt_q < LED_LAST) begin
                        shreg_q   <= nxt_q;
                        led_cnt_q <= led_cnt_q + 1'b1;
                        bit_idx_q <= 5'd23;
                        bit_cnt_q <= '0;
                        dout_q    <= hi(nxt_q[23], '0);
                    end else begin
                        state_q   <= LATCH;
                        bit_cnt_q <= '0;
                        dout_q    <= 1'b0;
                    end
                end
                LATCH: begin
                    if (bit_cnt_q == RST_LAST) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdaddress = rdaddr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dout      = dout_q;

endmodule
